// File: rtl/decode_pkg.sv
// Shared constants for the MIPS decode stage: opcodes, instruction field positions,
// FSM state encoding and helpers for the packed channel widths.
package decode_pkg;

    localparam int INSTR_W  = 32;
    localparam int OP_LSB   = 26;
    localparam int RS_LSB   = 21;
    localparam int RT_LSB   = 16;
    localparam int RD_LSB   = 11;
    localparam int SH_LSB   = 6;
    localparam int FN_LSB   = 0;
    localparam int IMM_W    = 16;
    localparam int IDX_W    = 26;
    localparam int JAL_LINK = 31;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ISSUE = 2'd2
    } dec_state_e;

    // One write-back port is {data, reg, wen}.
    function automatic int wb_port_w(input int xlen, input int rw);
        return xlen + rw + 1;
    endfunction

    function automatic int d2e_w(input int xlen, input int rw, input int pcw);
        return 17 + 3 * xlen + rw + pcw;
    endfunction

    function automatic logic is_alu_imm(input logic [5:0] op);
        return op[5:3] == 3'b001;
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op >= 6'h20) && (op <= 6'h25);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file plus pending-destination scoreboard with NWB write ports and two read ports.
// WB_BYPASS_EN: same-cycle write-back data is forwarded to the read ports and masks their pending bit.
module decode_regfile
    import decode_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int NWB  = 2,
    localparam int RW   = $clog2(NREG),
    localparam int WBW  = wb_port_w(XLEN, RW)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NWB-1:0]     wb_vld,
    input  logic [NWB*WBW-1:0] wb_bus,
    input  logic               set_vld,
    input  logic [RW-1:0]      set_reg,
    input  logic [RW-1:0]      ra_reg,
    input  logic [RW-1:0]      rb_reg,
    output logic [XLEN-1:0]    ra_val,
    output logic [XLEN-1:0]    rb_val,
    output logic               ra_pend,
    output logic               rb_pend
);

    logic [XLEN-1:0] regs    [NREG];
    logic [NREG-1:0] pend;
    logic [NWB-1:0]  wb_wen;
    logic [RW-1:0]   wb_reg  [NWB];
    logic [XLEN-1:0] wb_data [NWB];

    for (genvar i = 0; i < NWB; i++) begin : g_wb
        assign wb_data[i] = wb_bus[i*WBW+RW+1 +: XLEN];
        assign wb_reg[i]  = wb_bus[i*WBW+1 +: RW];
        assign wb_wen[i]  = wb_vld[i] & wb_bus[i*WBW] & (wb_bus[i*WBW+1 +: RW] != '0);
    end

    // Descending port order: the lowest-index port's assignment lands last and wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
            pend <= '0;
        end else begin
            for (int i = NWB - 1; i >= 0; i--) begin
                if (wb_wen[i]) begin
                    regs[wb_reg[i]] <= wb_data[i];
                    pend[wb_reg[i]] <= 1'b0;
                end
            end
            if (set_vld && (set_reg != '0)) pend[set_reg] <= 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    logic [1:0]      byp_hit;
    logic [XLEN-1:0] byp_val [2];

    always_comb begin
        byp_hit    = '0;
        byp_val[0] = '0;
        byp_val[1] = '0;
        for (int i = NWB - 1; i >= 0; i--) begin
            if (wb_wen[i] && (wb_reg[i] == ra_reg)) begin
                byp_hit[0] = 1'b1;
                byp_val[0] = wb_data[i];
            end
            if (wb_wen[i] && (wb_reg[i] == rb_reg)) begin
                byp_hit[1] = 1'b1;
                byp_val[1] = wb_data[i];
            end
        end
    end

    assign ra_val  = byp_hit[0] ? byp_val[0] : regs[ra_reg];
    assign rb_val  = byp_hit[1] ? byp_val[1] : regs[rb_reg];
    assign ra_pend = pend[ra_reg] & ~byp_hit[0];
    assign rb_pend = pend[rb_reg] & ~byp_hit[1];
`else
    assign ra_val  = regs[ra_reg];
    assign rb_val  = regs[rb_reg];
    assign ra_pend = pend[ra_reg];
    assign rb_pend = pend[rb_reg];
`endif

endmodule

// File: rtl/decode_stage_sb.sv
// MIPS decode stage: IDLE/CHECK/ISSUE handshake FSM with scoreboard stall and branch resolution.
// Optional WB_BYPASS_EN (see decode_regfile) lets a stalled source issue on its write-back edge.
module decode_stage_sb
    import decode_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int PCW  = 32,
    parameter  int NWB  = 2,
    localparam int RW   = $clog2(NREG),
    localparam int WBW  = wb_port_w(XLEN, RW),
    localparam int D2EW = d2e_w(XLEN, RW, PCW)
) (
    input  logic                   clk,
    input  logic                   Z_R,
    input  logic                   f2d_R,
    output logic                   f2d_A,
    input  logic [INSTR_W+PCW-1:0] f2d,
    input  logic [NWB-1:0]         w2d_R,
    output logic [NWB-1:0]         w2d_A,
    input  logic [NWB*WBW-1:0]     w2d,
    output logic                   d2f_R,
    input  logic                   d2f_A,
    output logic [PCW:0]           d2f,
    output logic                   d2e_R,
    input  logic                   d2e_A,
    output logic [D2EW-1:0]        d2e
);

    dec_state_e          state, state_nxt;
    logic                run;
    logic                f2d_xfer, issue_go, hazard;
    logic [INSTR_W-1:0]  instr_p0;
    logic [PCW-1:0]      pc4_p0;
    logic [5:0]          op;
    logic [RW-1:0]       rs, rt, rd, dest;
    logic                rs_used, rt_used, rs_pend, rt_pend, taken;
    logic [XLEN-1:0]     rs_val, rt_val;
    logic signed [XLEN-1:0] imm_sext;
    logic signed [PCW-1:0]  br_off;
    logic [PCW-1:0]      target;

    // run rises on the first edge after reset release and gates every ready output.
    assign f2d_A = run && (state == ST_IDLE);
    assign w2d_A = {NWB{run}};

    decode_regfile #(.XLEN(XLEN), .NREG(NREG), .NWB(NWB)) u_regfile (
        .clk    (clk),
        .rst_n  (Z_R),
        .wb_vld (w2d_R & w2d_A),
        .wb_bus (w2d),
        .set_vld(issue_go),
        .set_reg(dest),
        .ra_reg (rs),
        .rb_reg (rt),
        .ra_val (rs_val),
        .rb_val (rt_val),
        .ra_pend(rs_pend),
        .rb_pend(rt_pend)
    );

    assign op      = instr_p0[OP_LSB +: 6];
    assign rs      = RW'(instr_p0[RS_LSB +: 5]);
    assign rt      = RW'(instr_p0[RT_LSB +: 5]);
    assign rd      = RW'(instr_p0[RD_LSB +: 5]);
    assign rs_used = !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI));
    assign rt_used = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || is_store(op);
    assign hazard  = (rs_used && rs_pend) || (rt_used && rt_pend);
    assign br_off  = {{(PCW-IMM_W-2){instr_p0[IMM_W-1]}}, instr_p0[IMM_W-1:0], 2'b00};

    always_comb begin
        if ((op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI))
            imm_sext = {{(XLEN-IMM_W){1'b0}}, instr_p0[IMM_W-1:0]};
        else
            imm_sext = {{(XLEN-IMM_W){instr_p0[IMM_W-1]}}, instr_p0[IMM_W-1:0]};
    end

    always_comb begin
        dest = '0;
        if (op == OP_RTYPE)                  dest = rd;
        else if (op == OP_JAL)               dest = RW'(JAL_LINK);
        else if (is_alu_imm(op) || is_load(op)) dest = rt;
    end

    always_comb begin
        taken  = 1'b0;
        target = pc4_p0;
        if ((op == OP_BEQ) || (op == OP_BNE)) begin
            taken  = (op == OP_BEQ) ? (rs_val == rt_val) : (rs_val != rt_val);
            target = pc4_p0 + br_off;
        end else if ((op == OP_J) || (op == OP_JAL)) begin
            taken  = 1'b1;
            target = {pc4_p0[PCW-1:28], instr_p0[IDX_W-1:0], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge Z_R) begin
        if (!Z_R) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        f2d_xfer  = 1'b0;
        issue_go  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                f2d_xfer = f2d_R && f2d_A;
                if (f2d_xfer) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (!hazard) begin
                    issue_go  = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if ((!d2e_R || d2e_A) && (!d2f_R || d2f_A)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0 holds the fetched token; stage p1 is the issued d2e/d2f bundle.
    always_ff @(posedge clk or negedge Z_R) begin
        if (!Z_R) begin
            run      <= 1'b0;
            instr_p0 <= '0;
            pc4_p0   <= '0;
            d2e_R    <= 1'b0;
            d2f_R    <= 1'b0;
            d2e      <= '0;
            d2f      <= '0;
        end else begin
            run <= 1'b1;
            if (f2d_xfer) begin
                instr_p0 <= f2d[PCW +: INSTR_W];
                pc4_p0   <= f2d[PCW-1:0];
            end
            if (issue_go) begin
                d2e_R <= 1'b1;
                d2f_R <= 1'b1;
                d2e   <= {op, instr_p0[FN_LSB +: 6], instr_p0[SH_LSB +: 5],
                          rs_val, rt_val, imm_sext, dest, pc4_p0};
                d2f   <= {taken, target};
            end else begin
                if (d2e_R && d2e_A) d2e_R <= 1'b0;
                if (d2f_R && d2f_A) d2f_R <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_sb.sv
// Self-checking bench for decode_stage_sb: directed scenarios, then random instructions
// checked against an architectural register/pending model. Honours WB_BYPASS_EN.
module tb_decode_stage_sb;

    localparam int D2EW = 150;
    localparam int WBW  = 38;
`ifdef WB_BYPASS_EN
    localparam int BYP_LAT = 0;
`else
    localparam int BYP_LAT = 1;
`endif

    typedef logic [159:0] cv_t;

    logic             clk = 1'b0;
    logic             Z_R;
    logic             f2d_R;
    logic             f2d_A;
    logic [63:0]      f2d;
    logic [1:0]       w2d_R;
    logic [1:0]       w2d_A;
    logic [2*WBW-1:0] w2d;
    logic             d2f_R;
    logic             d2f_A;
    logic [32:0]      d2f;
    logic             d2e_R;
    logic             d2e_A;
    logic [D2EW-1:0]  d2e;

    int tests = 0;
    int fails = 0;

    logic [31:0] mreg [32];
    logic [31:0] mpend;

    decode_stage_sb dut (
        .clk  (clk),
        .Z_R  (Z_R),
        .f2d_R(f2d_R),
        .f2d_A(f2d_A),
        .f2d  (f2d),
        .w2d_R(w2d_R),
        .w2d_A(w2d_A),
        .w2d  (w2d),
        .d2f_R(d2f_R),
        .d2f_A(d2f_A),
        .d2f  (d2f),
        .d2e_R(d2e_R),
        .d2e_A(d2e_A),
        .d2e  (d2e)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input cv_t obs, input cv_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) mreg[r] = '0;
        mpend = '0;
    endtask

    function automatic int opc(input logic [31:0] ins);
        return int'(ins[31:26]);
    endfunction

    function automatic logic rs_used(input logic [31:0] ins);
        return !(opc(ins) == 2 || opc(ins) == 3 || opc(ins) == 15);
    endfunction

    function automatic logic rt_used(input logic [31:0] ins);
        int op = opc(ins);
        return op == 0 || op == 4 || op == 5 || op == 40 || op == 41 || op == 43;
    endfunction

    function automatic int exp_dest(input logic [31:0] ins);
        int op = opc(ins);
        if (op == 0) return int'(ins[15:11]);
        if (op == 3) return 31;
        if ((op >= 8 && op <= 15) || (op >= 32 && op <= 37)) return int'(ins[20:16]);
        return 0;
    endfunction

    function automatic logic [D2EW-1:0] exp_d2e(input logic [31:0] ins, input logic [31:0] pc4,
                                                input logic [31:0] rsv, input logic [31:0] rtv);
        logic [31:0] imm;
        int op = opc(ins);
        if (op == 12 || op == 13 || op == 14) imm = 32'(ins[15:0]);
        else imm = 32'(int'($signed(ins[15:0])));
        return {ins[31:26], ins[5:0], ins[10:6], rsv, rtv, imm, 5'(exp_dest(ins)), pc4};
    endfunction

    function automatic logic [32:0] exp_d2f(input logic [31:0] ins, input logic [31:0] pc4,
                                            input logic [31:0] rsv, input logic [31:0] rtv);
        int op = opc(ins);
        int off;
        if (op == 4 || op == 5) begin
            off = int'($signed(ins[15:0])) * 4;
            return {(op == 4) ? (rsv == rtv) : (rsv != rtv), pc4 + 32'(off)};
        end
        if (op == 2 || op == 3) return {1'b1, (pc4 & 32'hF000_0000) | (32'(ins[25:0]) << 2)};
        return {1'b0, pc4};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs  = 5'($urandom_range(0, 7));
        logic [4:0]  rt  = 5'($urandom_range(0, 7));
        logic [4:0]  rd  = 5'($urandom_range(0, 7));
        logic [15:0] imm = 16'($urandom);
        logic [5:0]  fns [6] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h2A};
        logic [5:0]  ops [9] = '{6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h0A};
        int k = $urandom_range(0, 11);
        if (k < 2)  return {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), fns[$urandom_range(0, 5)]};
        if (k == 2) return {6'h02, 26'($urandom)};
        if (k == 3) return {6'h03, 26'($urandom)};
        return {ops[k-3], rs, rt, imm};
    endfunction

    task automatic wb2(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        w2d   = {d1, r1, 1'b1, d0, r0, 1'b1};
        w2d_R = {v1, v0};
        step();
        w2d_R = 2'b00;
        if (v1 && r1 != 0) begin mreg[r1] = d1; mpend[r1] = 1'b0; end
        if (v0 && r0 != 0) begin mreg[r0] = d0; mpend[r0] = 1'b0; end
    endtask

    task automatic wb_one(input logic [4:0] r, input logic [31:0] d);
        if ($urandom_range(0, 1) == 0) wb2(1'b1, r, d, 1'b0, 5'd0, 32'd0);
        else                           wb2(1'b0, 5'd0, 32'd0, 1'b1, r, d);
    endtask

    task automatic send_f2d(input logic [31:0] ins, input logic [31:0] pc4);
        int n = 0;
        while (!f2d_A && n < 20) begin step(); n++; end
        chk("f2d_ready", cv_t'(f2d_A), cv_t'(1));
        f2d   = {ins, pc4};
        f2d_R = 1'b1;
        step();
        f2d_R = 1'b0;
    endtask

    task automatic wait_issue(output int lat);
        lat = 0;
        while (!d2e_R && lat < 20) begin step(); lat++; end
    endtask

    // Sends one instruction, resolves any modelled hazard, checks issue timing and payloads.
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] pc4,
                             input logic [31:0] wbseed, input logic wb_now);
        logic [4:0]  rs = ins[25:21];
        logic [4:0]  rt = ins[20:16];
        logic        hs = rs_used(ins) && mpend[rs];
        logic        ht = rt_used(ins) && mpend[rt];
        logic [31:0] d0, d1;
        int          lat, d;
        send_f2d(ins, pc4);
        if (hs || ht) begin
            repeat ($urandom_range(1, 3)) begin
                chk("stall_hold", cv_t'({d2e_R, d2f_R}), cv_t'(0));
                step();
            end
            d0 = (wbseed != 0) ? wbseed : $urandom;
            d1 = $urandom;
            if (hs && ht && rs != rt) wb2(1'b1, rs, d0, 1'b1, rt, d1);
            else if (hs)              wb_one(rs, d0);
            else                      wb_one(rt, d0);
            wait_issue(lat);
            chk("wb_to_issue_lat", cv_t'(lat), cv_t'(BYP_LAT));
        end else begin
            wait_issue(lat);
            chk("issue_lat", cv_t'(lat), cv_t'(1));
        end
        chk("d2f_R", cv_t'(d2f_R), cv_t'(1));
        chk("d2e", cv_t'(d2e), cv_t'(exp_d2e(ins, pc4, mreg[rs], mreg[rt])));
        chk("d2f", cv_t'(d2f), cv_t'(exp_d2f(ins, pc4, mreg[rs], mreg[rt])));
        d2e_A = 1'b1;
        d2f_A = 1'b1;
        step();
        d2e_A = 1'b0;
        d2f_A = 1'b0;
        chk("drop_after_xfer", cv_t'({d2e_R, d2f_R}), cv_t'(0));
        chk("f2d_A_after_issue", cv_t'(f2d_A), cv_t'(1));
        d = exp_dest(ins);
        if (d != 0) begin
            mpend[d] = 1'b1;
            if (wb_now) wb_one(5'(d), $urandom);
        end
    endtask

    initial begin
        int lat;
        model_reset();
        Z_R   = 1'b0;
        f2d_R = 1'b1;
        f2d   = {32'h2001_0005, 32'h4};
        w2d_R = '0;
        w2d   = '0;
        d2e_A = 1'b0;
        d2f_A = 1'b0;

        // Reset holds every ready/valid low even with a pending fetch token.
        repeat (3) step();
        chk("rst_f2d_A", cv_t'(f2d_A), cv_t'(0));
        chk("rst_d2e_R", cv_t'(d2e_R), cv_t'(0));
        chk("rst_d2f_R", cv_t'(d2f_R), cv_t'(0));
        chk("rst_w2d_A", cv_t'(w2d_A), cv_t'(0));
        chk("rst_payload", cv_t'({d2e, d2f}), cv_t'(0));
        f2d_R = 1'b0;
        Z_R   = 1'b1;
        chk("rel_f2d_A_same", cv_t'(f2d_A), cv_t'(0));
        step();
        chk("rel_f2d_A_next", cv_t'(f2d_A), cv_t'(1));
        chk("rel_w2d_A_next", cv_t'(w2d_A), cv_t'(2'b11));

        // addi $1,$0,5 leaves $1 pending; add $2,$1,$1 then stalls until write-back of 5.
        run_instr(32'h2001_0005, 32'h4, 32'd0, 1'b0);
        chk("pend1_model", cv_t'(mpend[1]), cv_t'(1));
        run_instr(32'h0021_1020, 32'h8, 32'd5, 1'b1);

        // Branches and jal.
        run_instr(32'h1000_FFFF, 32'h100, 32'd0, 1'b0);
        run_instr(32'h1400_FFFF, 32'h100, 32'd0, 1'b0);
        run_instr(32'h0C00_0040, 32'h100, 32'd0, 1'b1);

        // Dual write to $7: port 0 wins. Write to $0 is ignored and never pends.
        wb2(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        chk("dual_wb_model", cv_t'(mreg[7]), cv_t'(32'hA));
        run_instr(32'h00E0_1820, 32'h200, 32'd0, 1'b1);
        wb2(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        run_instr(32'h0000_2020, 32'h204, 32'd0, 1'b1);

        // d2e back-pressure while d2f is taken.
        send_f2d(32'h3405_1234, 32'h300);
        wait_issue(lat);
        chk("bp_issue_lat", cv_t'(lat), cv_t'(1));
        d2f_A = 1'b1;
        step();
        d2f_A = 1'b0;
        chk("bp_d2f_dropped", cv_t'(d2f_R), cv_t'(0));
        for (int i = 0; i < 5; i++) begin
            chk("bp_d2e_R", cv_t'(d2e_R), cv_t'(1));
            chk("bp_d2e", cv_t'(d2e), cv_t'(exp_d2e(32'h3405_1234, 32'h300, 32'd0, 32'd0)));
            chk("bp_f2d_A", cv_t'(f2d_A), cv_t'(0));
            step();
        end
        d2e_A = 1'b1;
        step();
        d2e_A = 1'b0;
        chk("bp_d2e_done", cv_t'(d2e_R), cv_t'(0));
        chk("bp_f2d_A_back", cv_t'(f2d_A), cv_t'(1));
        mpend[5] = 1'b1;
        wb_one(5'd5, 32'h1234);

        // Reset while an instruction is stalled drops it.
        run_instr(32'h2009_0001, 32'h400, 32'd0, 1'b0);
        send_f2d(32'h0129_5020, 32'h404);
        step();
        Z_R = 1'b0;
        step();
        Z_R = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid_no_token", cv_t'({d2e_R, d2f_R}), cv_t'(0));
            step();
        end
        chk("rst_mid_f2d_A", cv_t'(f2d_A), cv_t'(1));

        // Random instruction stream against the model.
        for (int n = 0; n < 60; n++) begin
            run_instr(rand_instr(), {30'($urandom), 2'b00}, 32'd0, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
